// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed load/store unit in front of word-addressed DMEM, with read-modify-write for sub-word stores.
// Optional per-type response counters: define DMEM_LSU_STATS_EN.
module dmem_lsu #(
    parameter int MEM_RD_LATENCY = 1,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-3:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic              mem_read_write,
    input  logic [31:0]       mem_data_out
`ifdef DMEM_LSU_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errors
`endif
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q, uns_q, err_q;
    logic [31:0]       wdata_q, word_q, merged, load_val;
    logic [1:0]        cnt_q;
    logic              accept, misalign, last_wait;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign accept    = req_valid && req_ready;
    assign misalign  = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign last_wait = cnt_q == 2'(MEM_RD_LATENCY - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = misalign ? RESP : (req_write && req_size == 2'b10) ? WRITE : READ;
            READ:  state_d = WAIT;
            WAIT:  if (last_wait) state_d = write_q ? WRITE : RESP;
            WRITE: state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                write_q <= req_write;
                uns_q   <= req_unsigned;
                err_q   <= misalign;
                wdata_q <= req_wdata;
            end
            if (state_q == READ) cnt_q <= '0;
            if (state_q == WAIT) cnt_q <= cnt_q + 2'd1;
            if (state_q == WAIT && last_wait) word_q <= mem_data_out;
        end
    end

    assign lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = word_q[{addr_q[1], 4'b0000} +: 16];
    assign load_val = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b}
                    : size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h} : word_q;

    // Untouched lanes come from the word just read back, since DMEM has no byte enables
    always_comb begin
        merged = word_q;
        if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    assign req_ready      = state_q == IDLE && reset;
    assign resp_valid     = state_q == RESP;
    assign resp_error     = resp_valid && err_q;
    assign resp_rdata     = (resp_valid && !err_q && !write_q) ? load_val : '0;
    assign mem_address    = (state_q == READ || state_q == WAIT || state_q == WRITE) ? addr_q[ADDR_W-1:2] : '0;
    assign mem_read_write = state_q == WRITE;
    assign mem_data_in    = state_q == WRITE ? (size_q == 2'b10 ? wdata_q : merged) : '0;

`ifdef DMEM_LSU_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (resp_valid) begin
            if (err_q && stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
            if (!err_q && write_q && stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            if (!err_q && !write_q && stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu against a behavioural DMEM with configurable read latency.
module tb_dmem_lsu;
    localparam int L = 1;

    logic        clock = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [14:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_error, mem_read_write;
    logic [31:0] resp_rdata, mem_data_in, mem_data_out;
    logic [12:0] mem_address;
`ifdef DMEM_LSU_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

    dmem_lsu #(.MEM_RD_LATENCY(L), .ADDR_W(15)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
`ifdef DMEM_LSU_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:8191];
    logic [31:0] rd_pipe [0:L-1];
    int          cyc = 0, wr_cnt = 0, wr_cyc = 0;
    logic [12:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    assign mem_data_out = rd_pipe[L-1];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem[mem_address];
        if (mem_read_write) begin
            mem[mem_address] <= mem_data_in;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_address;
            wr_data <= mem_data_in;
            wr_cyc  <= cyc;
        end
    end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          at;
    } exp_t;
    exp_t q[$];

    always @(negedge clock) begin
        if (resp_valid) begin
            if (q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("resp_rdata", resp_rdata, e.rd);
                check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                check("resp_cycle", 32'(cyc), 32'(e.at));
            end
        end else if (resp_rdata !== 32'd0) check("rdata_idle_zero", resp_rdata, 32'd0);
    end

    // lat is the response cycle offset from the accept edge T
    task automatic send(input logic wr, input logic [1:0] sz, input logic uns, input logic [14:0] a,
                        input logic [31:0] wd, input logic expect_resp, input logic [31:0] erd,
                        input logic eerr, input int lat, output int acc);
        exp_t e;
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        acc = cyc;
        if (expect_resp) begin
            e.rd = erd; e.err = eerr; e.at = acc + lat;
            q.push_back(e);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) check("resp_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int acc, w0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rw", {31'd0, mem_read_write}, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        send(1, 2'b10, 0, 15'h0000, 32'hA5A5A5A5, 1, 32'd0, 0, 2, acc);
        wait_idle();
        check("ws0_addr", {19'd0, wr_addr}, 32'h0);
        check("ws0_data", wr_data, 32'hA5A5A5A5);
        check("ws0_wcyc", 32'(wr_cyc), 32'(acc + 1));
        send(0, 2'b10, 0, 15'h0000, 32'd0, 1, 32'hA5A5A5A5, 0, 2 + L, acc);
        wait_idle();

        send(1, 2'b10, 0, 15'h1010, 32'h12345678, 1, 32'd0, 0, 2, acc);
        wait_idle();
        check("bank_addr", {19'd0, wr_addr}, 32'h0404);
        send(0, 2'b10, 0, 15'h1010, 32'd0, 1, 32'h12345678, 0, 2 + L, acc);
        wait_idle();

        send(1, 2'b10, 0, 15'h2020, 32'h15328054, 1, 32'd0, 0, 2, acc);
        wait_idle();
        send(1, 2'b00, 0, 15'h2021, 32'hFFFFFFEF, 1, 32'd0, 0, 3 + L, acc);
        wait_idle();
        check("bst_data", wr_data, 32'h1532EF54);
        check("bst_addr", {19'd0, wr_addr}, 32'h0808);
        check("bst_wcyc", 32'(wr_cyc), 32'(acc + 2 + L));
        send(0, 2'b10, 0, 15'h2020, 32'd0, 1, 32'h1532EF54, 0, 2 + L, acc);
        wait_idle();

        send(1, 2'b10, 0, 15'h2020, 32'h80010000, 1, 32'd0, 0, 2, acc);
        send(0, 2'b01, 0, 15'h2022, 32'd0, 1, 32'hFFFF8001, 0, 2 + L, acc);
        send(0, 2'b01, 1, 15'h2022, 32'd0, 1, 32'h00008001, 0, 2 + L, acc);
        send(0, 2'b00, 0, 15'h2023, 32'd0, 1, 32'hFFFFFF80, 0, 2 + L, acc);
        send(0, 2'b00, 1, 15'h2023, 32'd0, 1, 32'h00000080, 0, 2 + L, acc);
        send(0, 2'b00, 0, 15'h2022, 32'd0, 1, 32'h00000001, 0, 2 + L, acc);
        send(1, 2'b01, 0, 15'h2020, 32'h0000BEEF, 1, 32'd0, 0, 3 + L, acc);
        send(0, 2'b10, 0, 15'h2020, 32'd0, 1, 32'h8001BEEF, 0, 2 + L, acc);
        wait_idle();

        w0 = wr_cnt;
        send(0, 2'b10, 0, 15'h0002, 32'd0, 1, 32'd0, 1, 1, acc);
        send(1, 2'b11, 0, 15'h0000, 32'hDEADBEEF, 1, 32'd0, 1, 1, acc);
        send(1, 2'b01, 0, 15'h0001, 32'hDEADBEEF, 1, 32'd0, 1, 1, acc);
        wait_idle();
        check("err_no_write", 32'(wr_cnt), 32'(w0));

        w0 = wr_cnt;
        send(1, 2'b00, 0, 15'h0005, 32'h00000077, 0, 32'd0, 0, 0, acc);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_rw", {31'd0, mem_read_write}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd0);
        check("abort_addr", {19'd0, mem_address}, 32'd0);
        check("abort_valid", {31'd0, resp_valid}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1 check("abort_ready_rel", {31'd0, req_ready}, 32'd1);
`ifdef DMEM_LSU_STATS_EN
        check("stat_loads_rst", {16'd0, stat_loads}, 32'd0);
        check("stat_stores_rst", {16'd0, stat_stores}, 32'd0);
        check("stat_errors_rst", {16'd0, stat_errors}, 32'd0);
`endif
        send(0, 2'b10, 0, 15'h0000, 32'd0, 1, 32'hA5A5A5A5, 0, 2 + L, acc);
        wait_idle();
        check("abort_no_write", 32'(wr_cnt), 32'(w0));
        check("word1_intact", mem[1], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit directly upstream of the data-memory top level. Accepts byte-addressed CPU load/store requests over a valid/ready handshake and converts them into the word-addressed DMEM interface: 13-bit address with bank in [12:10] and word in [9:0], a 32-bit write bus, and a read_write strobe. Handles byte and halfword accesses: loads are extracted and extended; stores use a read-modify-write sequence because DMEM has no byte enables. Rejects misaligned requests with an error response.

Parameters:
MEM_RD_LATENCY, 1, cycles from a read address being presented until mem_data_out is valid (1..4)
ADDR_W, 15, byte-address width; word address = req_addr[ADDR_W-1:2] (13 bits)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  unit can accept a request (high only in IDLE, low while reset asserted)
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_W  byte address, little-endian
req_wdata  in  32  store data, right-aligned for byte/half
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_rdata  out  32  load result (0 for stores and errors)
resp_error  out  1  qualifies resp_valid: misaligned or illegal size
mem_address  out  13  to DMEM address; [12:10] bank, [9:0] word
mem_data_in  out  32  to DMEM data_in
mem_read_write  out  1  to DMEM read_write; 1=write, 0=read
mem_data_out  in  32  from DMEM dataOut

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; latched request cleared. Reset mid-operation aborts: mem_read_write drops to 0 immediately, no write completes, no response is issued.
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: req_ready=1, mem_read_write=0. A request is accepted on the rising edge where req_valid&&req_ready; addr, size, write, unsigned and wdata are latched. Nothing is accepted outside IDLE.
- Alignment check at acceptance: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> go to RESP with resp_error=1; no DMEM access.
- Word store: WRITE for 1 cycle (mem_address=addr[14:2], mem_data_in=wdata, mem_read_write=1) -> RESP.
- Load, or byte/half store: READ for 1 cycle (address driven, rw=0) -> WAIT for MEM_RD_LATENCY cycles. mem_data_out is sampled on the final WAIT edge into a word register. A load then goes to RESP. A sub-word store goes to WRITE with the merged word: the byte/half lane at offset addr[1:0] (byte lane k = bits [8k+7:8k]) is replaced with wdata low bits and the other lanes are kept.
- mem_address is held stable from READ through WRITE.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. The next request can be accepted on the edge that ends RESP+1 (req_ready asserts in the cycle after RESP).
- Latency from the accept edge T (cycles in which resp_valid is high): error T+1; word store T+2; load T+2+L; sub-word store T+3+L, where L=MEM_RD_LATENCY.
- Load extraction: byte = lane addr[1:0]; half = lane pair addr[1]. Extended to 32 bits per req_unsigned.
- resp_rdata is 0 except on a successful load response. It holds its value only while resp_valid is high and returns to 0 afterwards.
- Address wrap is impossible: all 13 word-address bits map directly, covering all 8 banks.

Optional Feature:
DMEM_LSU_STATS_EN: when defined, adds three 16-bit outputs: stat_loads, stat_stores, stat_errors. Each increments on its respective resp_valid, saturates at 16'hFFFF, and clears on reset. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Word store 32'hA5A5A5A5 @ byte addr 15'h0000, then word load @ 15'h0000 -> DMEM write at word 0 on T+1; load resp_rdata=32'hA5A5A5A5, resp_error=0, resp_valid at T+3 (L=1).
- Bank crossing: word store 32'h12345678 @ 15'h1010 (bank 1, word 4) -> mem_address=13'h0404 with rw=1; readback matches.
- Byte store 8'hEF @ 15'h2021 over an existing word 32'h15328054 -> READ then WRITE of 32'h1532EF54; resp_valid at T+4.
- Signed/unsigned loads of half @ 15'h2022 from word 32'h8001_0000 -> signed 32'hFFFF8001, unsigned 32'h00008001; byte @ offset 3 signed -> 32'hFFFFFF80.
- Misaligned word load @ 15'h0002 and size=11 -> resp_error=1 at T+1, resp_rdata=0, mem_read_write never asserted.
- reset driven low during WAIT of a byte store -> outputs 0 immediately, no DMEM write, no resp_valid; after release, req_ready=1 and a new word load succeeds. With DMEM_LSU_STATS_EN, counters read 0 after reset.
